// File: rtl/memoredf_pkg.sv
// Shared types and helpers for the MemorEDF scheduler datapath.
// The forwarder FSM encoding and the queue-id width rule live here.
package memoredf_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } forwarder_state_t;

    // Width of a queue index; a single queue still gets a 1-bit id.
    function automatic int queue_id_width(input int number_of_queues);
        return (number_of_queues > 1) ? $clog2(number_of_queues) : 1;
    endfunction

endpackage

// File: rtl/service_counters.sv
// Bank of per-queue service counters: one increment strobe with an index,
// a synchronous clear that beats a coincident increment, and natural wrap.
module service_counters
    import memoredf_pkg::*;
#(
    parameter int NUM_COUNTERS = 4,
    parameter int WIDTH        = 32,
    parameter int IDX_W        = 2
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                clear,
    input  logic                                inc,
    input  logic [IDX_W-1:0]                    inc_idx,
    output logic [NUM_COUNTERS-1:0][WIDTH-1:0]  count
);

    logic [NUM_COUNTERS-1:0][WIDTH-1:0] count_d, count_q;

    always_comb begin
        // NOTE: every comb output gets its hold value first so no path can infer a latch.
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc) begin
            count_d[inc_idx] = count_q[inc_idx] + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: this array is reset (unlike a RAM) because software reads it as status.
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/transaction_forwarder.sv
// Captures the granted queue head, offers it on a valid/ready port and returns
// a single-cycle consumed pulse to the scheduler; keeps service stats and error flags.
module transaction_forwarder
    import memoredf_pkg::*;
#(
    parameter int NUMBER_OF_QUEUES = 4,
    parameter int PACKET_SIZE      = 64,
    parameter int REGISTER_SIZE    = 32,
    localparam int ID_W            = queue_id_width(NUMBER_OF_QUEUES)
) (
    input  logic                                          clock,
    input  logic                                          reset,
    input  logic                                          enable,
    input  logic [ID_W-1:0]                               id,
    input  logic [NUMBER_OF_QUEUES-1:0]                   empty,
    input  logic [NUMBER_OF_QUEUES-1:0][PACKET_SIZE-1:0]  heads,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [PACKET_SIZE-1:0]                        out_data,
    output logic [ID_W-1:0]                               out_id,
    output logic                                          consumed,
    input  logic                                          clear_stats,
    output logic [NUMBER_OF_QUEUES-1:0][REGISTER_SIZE-1:0] served,
    output logic                                          err_underrun,
    output logic                                          err_overlap
);

    forwarder_state_t        state_d, state_q;
    logic [ID_W-1:0]         cur_id_d, cur_id_q;
    logic [PACKET_SIZE-1:0]  out_data_d, out_data_q;
    logic                    out_valid_d, out_valid_q;
    logic                    consumed_d, consumed_q;
    logic                    err_underrun_d, err_underrun_q;
    logic                    err_overlap_d, err_overlap_q;
    logic                    underrun_evt, overlap_evt, accept;

    always_comb begin
        state_d      = state_q;
        cur_id_d     = cur_id_q;
        out_data_d   = out_data_q;
        underrun_evt = 1'b0;
        overlap_evt  = 1'b0;
        accept       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (enable) begin
                    cur_id_d   = id;
                    out_data_d = heads[id];
                    // An empty queue still completes so the scheduler never stalls.
                    if (empty[id]) begin
                        underrun_evt = 1'b1;
                        state_d      = DONE;
                    end else begin
                        state_d = SEND;
                    end
                end
            end
            SEND: begin
                overlap_evt = enable;
                if (out_valid_q && out_ready) begin
                    accept  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                overlap_evt = enable;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they come straight off flops.
        out_valid_d = (state_d == SEND);
        consumed_d  = (state_d == DONE);

        err_underrun_d = clear_stats ? 1'b0 : (err_underrun_q | underrun_evt);
        err_overlap_d  = clear_stats ? 1'b0 : (err_overlap_q  | overlap_evt);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            cur_id_q       <= '0;
            out_data_q     <= '0;
            out_valid_q    <= 1'b0;
            consumed_q     <= 1'b0;
            err_underrun_q <= 1'b0;
            err_overlap_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            cur_id_q       <= cur_id_d;
            out_data_q     <= out_data_d;
            out_valid_q    <= out_valid_d;
            consumed_q     <= consumed_d;
            err_underrun_q <= err_underrun_d;
            err_overlap_q  <= err_overlap_d;
        end
    end

    service_counters #(
        .NUM_COUNTERS (NUMBER_OF_QUEUES),
        .WIDTH        (REGISTER_SIZE),
        .IDX_W        (ID_W)
    ) u_service_counters (
        .clk     (clock),
        .rst_n   (reset),
        .clear   (clear_stats),
        .inc     (accept),
        .inc_idx (cur_id_q),
        .count   (served)
    );

    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_id       = cur_id_q;
    assign consumed     = consumed_q;
    assign err_underrun = err_underrun_q;
    assign err_overlap  = err_overlap_q;

endmodule

// File: tb/tb_transaction_forwarder.sv
// Randomised bench for transaction_forwarder against a transaction-level model
// (expected packet, per-queue counts modulo 2^RS, sticky error flags).
module tb_transaction_forwarder;

    localparam int NQ   = 4;
    localparam int PS   = 64;
    localparam int RS   = 8;   // narrow counters so wrap is reachable in a short run
    localparam int IW   = 2;
    localparam int MAXV = (1 << RS) - 1;

    logic                   clock = 1'b0;
    logic                   reset;
    logic                   enable;
    logic [IW-1:0]          id;
    logic [NQ-1:0]          empty;
    logic [NQ-1:0][PS-1:0]  heads;
    logic                   out_valid;
    logic                   out_ready;
    logic [PS-1:0]          out_data;
    logic [IW-1:0]          out_id;
    logic                   consumed;
    logic                   clear_stats;
    logic [NQ-1:0][RS-1:0]  served;
    logic                   err_underrun;
    logic                   err_overlap;

    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned exp_served [NQ];
    bit          exp_underrun;
    bit          exp_overlap;

    always #5 clock = ~clock;

    transaction_forwarder #(
        .NUMBER_OF_QUEUES (NQ),
        .PACKET_SIZE      (PS),
        .REGISTER_SIZE    (RS)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .id           (id),
        .empty        (empty),
        .heads        (heads),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_id       (out_id),
        .consumed     (consumed),
        .clear_stats  (clear_stats),
        .served       (served),
        .err_underrun (err_underrun),
        .err_overlap  (err_overlap)
    );

    task automatic model_clear();
        for (int i = 0; i < NQ; i++) exp_served[i] = 0;
        exp_underrun = 1'b0;
        exp_overlap  = 1'b0;
    endtask

    // One grant, entered and left on a negedge. Stimulus changes on negedges,
    // outputs are sampled there too, half a cycle away from the active edge.
    task automatic run_grant(input int gid, input bit is_empty, input logic [PS-1:0] pkt,
                             input int wait_cycles, input bit mutate, input bit overlap,
                             input bit clear_hs);
        for (int i = 0; i < NQ; i++) heads[i] = {$urandom, $urandom};
        heads[gid]  = pkt;
        empty       = NQ'($urandom);
        empty[gid]  = is_empty;
        id          = IW'(gid);
        enable      = 1'b1;
        out_ready   = (wait_cycles == 0);
        @(negedge clock);
        enable = 1'b0;

        if (is_empty) begin
            exp_underrun = 1'b1;
            n_tests++;
            if (out_valid !== 1'b0) begin
                n_fail++; $display("FAIL underrun_valid: got %b want 0", out_valid);
            end
            n_tests++;
            if (consumed !== 1'b1) begin
                n_fail++; $display("FAIL underrun_consumed: got %b want 1", consumed);
            end
            @(negedge clock);
        end else begin
            for (int c = 0; c <= wait_cycles; c++) begin
                n_tests++;
                if (out_valid !== 1'b1 || consumed !== 1'b0) begin
                    n_fail++;
                    $display("FAIL send_valid c=%0d: valid=%b consumed=%b want 1/0", c, out_valid, consumed);
                end
                n_tests++;
                if (out_data !== pkt || out_id !== IW'(gid)) begin
                    n_fail++;
                    $display("FAIL send_data c=%0d: got %h/%0d want %h/%0d", c, out_data, out_id, pkt, gid);
                end
                if (mutate) heads[gid] = ~heads[gid];
                if (overlap && c == 0) begin
                    enable      = 1'b1;
                    id          = IW'($urandom);
                    exp_overlap = 1'b1;
                end else begin
                    enable = 1'b0;
                end
                out_ready   = (c >= wait_cycles);
                clear_stats = clear_hs && (c >= wait_cycles);
                @(negedge clock);
            end
            enable      = 1'b0;
            clear_stats = 1'b0;
            exp_served[gid] = (exp_served[gid] + 1) % (MAXV + 1);
            if (clear_hs) model_clear();
            n_tests++;
            if (out_valid !== 1'b0 || consumed !== 1'b1) begin
                n_fail++;
                $display("FAIL done_pulse: valid=%b consumed=%b want 0/1", out_valid, consumed);
            end
            @(negedge clock);
        end

        out_ready = 1'b0;
        n_tests++;
        if (consumed !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL pulse_end: consumed=%b valid=%b want 0/0", consumed, out_valid);
        end
        for (int i = 0; i < NQ; i++) begin
            n_tests++;
            if (served[i] !== RS'(exp_served[i])) begin
                n_fail++;
                $display("FAIL served[%0d]: got %0d want %0d", i, served[i], exp_served[i]);
            end
        end
        n_tests++;
        if (err_underrun !== exp_underrun || err_overlap !== exp_overlap) begin
            n_fail++;
            $display("FAIL err_flags: got %b%b want %b%b", err_underrun, err_overlap, exp_underrun, exp_overlap);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; enable = 1'b0; id = '0; empty = '0; heads = '0;
        out_ready = 1'b0; clear_stats = 1'b0;
        model_clear();
        repeat (2) @(negedge clock);
        n_tests++;
        if (out_valid !== 1'b0 || consumed !== 1'b0 || out_data !== '0 || out_id !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: valid=%b consumed=%b data=%h id=%0d want all 0",
                     out_valid, consumed, out_data, out_id);
        end
        n_tests++;
        if (served !== '0 || err_underrun !== 1'b0 || err_overlap !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_stats: served=%h flags=%b%b want 0", served, err_underrun, err_overlap);
        end
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_single();
        run_grant(2, 1'b0, 64'hDEAD_BEEF, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        run_grant(1, 1'b0, {$urandom, $urandom}, 5, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_underrun();
        run_grant(3, 1'b1, {$urandom, $urandom}, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_overlap();
        run_grant(0, 1'b0, {$urandom, $urandom}, 2, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 6; n++)
            run_grant(n % NQ, 1'b0, {$urandom, $urandom}, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++)
            run_grant(int'($urandom_range(NQ - 1)), ($urandom_range(3) == 0),
                      {$urandom, $urandom}, int'($urandom_range(4)),
                      1'($urandom), ($urandom_range(5) == 0), 1'b0);
    endtask

    task automatic test_wrap_clear();
        while (exp_served[0] != MAXV)
            run_grant(0, 1'b0, {$urandom, $urandom}, 0, 1'b0, 1'b0, 1'b0);
        run_grant(0, 1'b0, {$urandom, $urandom}, 0, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (served[0] !== '0) begin
            n_fail++; $display("FAIL wrap: got %0d want 0", served[0]);
        end
        // Raise both flags, then clear on the same edge as a handshake.
        run_grant(3, 1'b1, {$urandom, $urandom}, 0, 1'b0, 1'b0, 1'b0);
        run_grant(1, 1'b0, {$urandom, $urandom}, 1, 1'b0, 1'b1, 1'b1);
        n_tests++;
        if (served !== '0 || err_underrun !== 1'b0 || err_overlap !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_wins: served=%h flags=%b%b want 0", served, err_underrun, err_overlap);
        end
    endtask

    task automatic test_async_reset();
        empty = '0; heads[2] = {$urandom, $urandom};
        id = 2'd2; enable = 1'b1; out_ready = 1'b0;
        @(negedge clock);
        enable = 1'b0;
        n_tests++;
        if (out_valid !== 1'b1) begin
            n_fail++; $display("FAIL areset_pre: valid=%b want 1", out_valid);
        end
        #2 reset = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || consumed !== 1'b0 || served !== '0) begin
            n_fail++;
            $display("FAIL areset_clear: valid=%b consumed=%b served=%h want 0", out_valid, consumed, served);
        end
        model_clear();
        @(negedge clock);
        n_tests++;
        if (consumed !== 1'b0) begin
            n_fail++; $display("FAIL areset_noconsume: got %b want 0", consumed);
        end
        reset = 1'b1;
        @(negedge clock);
        run_grant(2, 1'b0, {$urandom, $urandom}, 1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_underrun();
        test_overlap();
        test_back_to_back();
        test_random();
        test_wrap_clear();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/transaction_forwarder.md
# transaction_forwarder

Downstream stage of the MemorEDF scheduler. Accepts the scheduler's one-cycle `enable` pulse with queue `id`, captures the head packet of that queue, presents it on a valid/ready output port toward the memory-side master, and returns a one-cycle `consumed` pulse once the packet is accepted. The scheduler turns that pulse into the `hasBeenConsumed` dequeue strobe and releases its pending transaction. The block also keeps per-queue service counters and sticky protocol-error flags.

## Interface
Parameters:
- `NUMBER_OF_QUEUES`, 4, number of scheduled queues
- `PACKET_SIZE`, 64, width of one queued transaction (address + attributes)
- `REGISTER_SIZE`, 32, width of each service counter

Ports:
- `clock`  in  1  sole clock
- `reset`  in  1  asynchronous, active-low reset
- `enable`  in  1  scheduler grant pulse
- `id`  in  $clog2(NUMBER_OF_QUEUES)  granted queue, valid with `enable`
- `empty`  in  NUMBER_OF_QUEUES  per-queue empty flags
- `heads`  in  [NUMBER_OF_QUEUES][PACKET_SIZE]  head element of each queue
- `out_valid`  out  1  packet valid toward master
- `out_ready`  in  1  master accepts packet
- `out_data`  out  PACKET_SIZE  forwarded packet
- `out_id`  out  $clog2(NUMBER_OF_QUEUES)  source queue of `out_data`
- `consumed`  out  1  completion pulse to scheduler
- `clear_stats`  in  1  synchronous clear of counters and error flags
- `served`  out  [NUMBER_OF_QUEUES][REGISTER_SIZE]  per-queue accepted-packet counts
- `err_underrun`  out  1  sticky: grant received for an empty queue
- `err_overlap`  out  1  sticky: grant received while busy

## Operation
- FSM states IDLE, SEND, DONE; reset state IDLE.
- IDLE: `out_valid`=0, `consumed`=0. On `enable`=1: register `cur_id`<=`id`, `out_data`<=`heads[id]`. If `empty[id]`=0 go SEND; else set `err_underrun` and go DONE directly (no output; `consumed` still pulses so the scheduler cannot deadlock; the queue ignores a pop on empty).
- SEND: `out_valid`=1, `out_data`/`out_id` held stable until handshake. `out_valid` never drops without handshake. On `out_valid & out_ready`: `served[cur_id]`++ , go DONE.
- DONE: `consumed`=1 for exactly this cycle; go IDLE unconditionally.
- `enable`=1 in SEND or DONE: ignored, `err_overlap` set.
- Counters wrap modulo 2^REGISTER_SIZE.
- `clear_stats`=1: all `served` and both error flags to 0 next edge; if coincident with an increment or error event, clear wins.
- Later changes on `heads` after capture have no effect on `out_data`.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_id`=0, `consumed`=0, `served`=0, error flags 0.
- All outputs registered.
- `enable` sampled at edge t -> `out_valid`=1 from t+1.
- Handshake at edge k -> `out_valid`=0 and `consumed`=1 during cycle k+1; `consumed`=0 from k+2.
- `out_ready` held high before `out_valid`: handshake at first SEND edge, i.e. `consumed` high 2 cycles after grant edge.
- `consumed` is always low-high-low, so the scheduler's rising-edge detector sees exactly one event per grant.
- Reset asserted mid-SEND: outputs clear immediately (asynchronous); packet is dropped, queue head untouched, no `consumed` emitted (scheduler is reset alongside).

## Structure
- Shared package `memoredf_pkg`: `forwarder_state_t` enum {IDLE, SEND, DONE}, `QUEUE_ID_WIDTH` function/localparam `$clog2(NUMBER_OF_QUEUES)`.
- One sub-module `service_counters` (counter bank: increment strobe + index, synchronous clear, wrap) instantiated once; FSM and capture registers live in the top.

## Test plan
- Single grant: `empty`=4'b1011 fails id 2 empty? use `empty`=4'b0000, `enable` with `id`=2, `heads[2]`=64'hDEAD_BEEF, `out_ready`=1 -> `out_valid` one cycle with `out_data`=64'hDEAD_BEEF, `out_id`=2, `consumed` one cycle later, `served[2]`=1.
- Backpressure: `out_ready`=0 for 5 cycles, `heads[1]` changed mid-wait -> `out_data` held at captured value, one `consumed` pulse after `out_ready` rises.
- Underrun: `enable`, `id`=3, `empty[3]`=1 -> no `out_valid`, `consumed` pulse at t+1, `err_underrun`=1, `served[3]` unchanged.
- Overlap: second `enable` during SEND -> ignored, `err_overlap`=1, exactly one `consumed`.
- Wrap/clear: preload `served[0]`=32'hFFFF_FFFF, one transfer -> 0; `clear_stats` coincident with handshake -> counters and flags 0.
- Async reset in SEND -> `out_valid`=0 before next clock edge, FSM IDLE, new grant after release served normally.
